// File: rtl/adrv9001_pkg.sv
// -----------------------------------------------------------------------------
// adrv9001_pkg
// Shared definitions for the ADRV9001 SSI transmit lane controller:
//   - link_state_e : 2-bit link state encoding (OFF/TRAIN/ACTIVE/DRAIN); the
//                    encoding is visible on the top-level state port.
//   - DRAIN_CYCLES : number of zero words sent before the lanes go high-Z.
//   - dw_legal()   : serialisation widths the OSERDES primitives support.
// -----------------------------------------------------------------------------
package adrv9001_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } link_state_e;

    localparam int DRAIN_CYCLES = 2;

    // The lane serialisers run in 4:1 or 8:1 mode only.
    function automatic bit dw_legal(input int width);
        return (width == 4) || (width == 8);
    endfunction

endpackage

// File: rtl/adrv9001_tx_lane_fmt.sv
// -----------------------------------------------------------------------------
// adrv9001_tx_lane_fmt
// Combinational formatter for one serial lane. The fabric word is MSB-first;
// the serialiser transmits bit 0 first, so the word is bit-reversed. Lanes
// whose P/N pins are swapped on the board get every bit inverted.
//
// Ports:
//   word  in   DATA_WIDTH  pre-format lane word (MSB transmitted first)
//   d     out  DATA_WIDTH  serialiser parallel input (bit 0 transmitted first)
// -----------------------------------------------------------------------------
module adrv9001_tx_lane_fmt
    import adrv9001_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit SWAP       = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] d
);

    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d[i] = word[DATA_WIDTH-1-i] ^ SWAP;
        end
    end

endmodule

// File: rtl/adrv9001_tx_lane_ctrl.sv
// -----------------------------------------------------------------------------
// adrv9001_tx_lane_ctrl
// Fabric-side transmit lane controller for the ADRV9001 LVDS/CMOS SSI. Runs
// the link state machine (OFF -> TRAIN -> ACTIVE -> DRAIN -> OFF), accepts
// parallel sample words over a valid/ready handshake, formats each lane for
// its serialiser and counts ACTIVE cycles starved of data. All outputs are
// registered on serdes_clk_div.
//
// Ports:
//   serdes_clk_div  in   1                 divided serdes clock (only clock)
//   rst             in   1                 async assert, active-high reset
//   enable          in   1                 link up (1) / down (0) request
//   s_data          in   LANES*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   s_valid         in   1                 s_data valid
//   s_ready         out  1                 high only while in ACTIVE
//   d               out  LANES*DATA_WIDTH  serialiser parallel inputs
//   t               out  LANES             serialiser tristate (1 = high-Z)
//   state           out  2                 0 OFF, 1 TRAIN, 2 ACTIVE, 3 DRAIN
//   underflow_cnt   out  16                saturating starved-cycle count
// -----------------------------------------------------------------------------
module adrv9001_tx_lane_ctrl
    import adrv9001_pkg::*;
#(
    parameter int               LANES         = 4,
    parameter int               DATA_WIDTH    = 8,
    parameter logic [LANES-1:0] SWAP_DIFF     = '0,
    parameter int               TRAIN_CYCLES  = 16,
    parameter logic [7:0]       TRAIN_PATTERN = 8'hA5
) (
    input  logic                        serdes_clk_div,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [LANES*DATA_WIDTH-1:0] s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [LANES*DATA_WIDTH-1:0] d,
    output logic [LANES-1:0]            t,
    output logic [1:0]                  state,
    output logic [15:0]                 underflow_cnt
);

    localparam int W   = LANES * DATA_WIDTH;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [DATA_WIDTH-1:0] PATTERN    = TRAIN_PATTERN[DATA_WIDTH-1:0];
    localparam logic [15:0]           TRAIN_LOAD = 16'(TRAIN_CYCLES - 1);
    localparam logic [DCW-1:0]        DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    // Formatted all-zero word: swapped lanes idle at all ones.
    function automatic logic [W-1:0] idle_word();
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{SWAP_DIFF[l]}};
        end
        return r;
    endfunction

    localparam logic [W-1:0] IDLE_D = idle_word();

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!dw_legal(DATA_WIDTH)) begin : g_bad_data_width
        $error("adrv9001_tx_lane_ctrl: DATA_WIDTH must be 4 or 8");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("adrv9001_tx_lane_ctrl: LANES must be 1..8");
    end
    if (TRAIN_CYCLES < 1 || TRAIN_CYCLES > 65535) begin : g_bad_train
        $error("adrv9001_tx_lane_ctrl: TRAIN_CYCLES must be 1..65535");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    link_state_e    state_q, state_d;
    logic [15:0]    train_cnt_q, train_cnt_d;   // words still to send after this one
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           run_q;                      // low for the first edge after reset
    logic [15:0]    ucnt_q;
    logic           ucnt_inc;
    logic           ucnt_clr;
    logic [W-1:0]   word_d;                     // pre-format word for the next cycle
    logic [W-1:0]   fmt_d;

    // ------------------------------------------------------------------
    // Next-state and next-word logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb infers a latch.
    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ucnt_inc    = 1'b0;
        ucnt_clr    = 1'b0;
        word_d      = '0;

        unique case (state_q)
            ST_OFF: begin
                if (run_q && enable) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = TRAIN_LOAD;
                    ucnt_clr    = 1'b1;
                end
            end
            ST_TRAIN: begin
                if (!enable) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (train_cnt_q == 16'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    train_cnt_d = train_cnt_q - 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    // Shutdown wins over a beat presented in the same cycle.
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (s_valid) begin
                    word_d = s_data;
                end else begin
                    ucnt_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Drain always runs to completion regardless of enable.
                if (drain_cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Training words are chosen from the state being entered so the
        // first pattern word leaves together with t dropping.
        if (state_d == ST_TRAIN) begin
            word_d = {LANES{PATTERN}};
        end
    end

    // ------------------------------------------------------------------
    // Per-lane formatting
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        adrv9001_tx_lane_fmt #(
            .DATA_WIDTH (DATA_WIDTH),
            .SWAP       (SWAP_DIFF[l])
        ) u_fmt (
            .word (word_d[l*DATA_WIDTH +: DATA_WIDTH]),
            .d    (fmt_d[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge serdes_clk_div or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            train_cnt_q <= '0;
            drain_cnt_q <= '0;
            run_q       <= 1'b0;
            ucnt_q      <= '0;
            d           <= IDLE_D;
            t           <= '1;
            s_ready     <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            d           <= fmt_d;
            t           <= {LANES{state_d == ST_OFF}};
            s_ready     <= (state_d == ST_ACTIVE);
            if (ucnt_clr) begin
                ucnt_q <= '0;
            end else if (ucnt_inc && ucnt_q != 16'hFFFF) begin
                ucnt_q <= ucnt_q + 16'd1;
            end
        end
    end

    assign state         = state_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_adrv9001_tx_lane_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adrv9001_tx_lane_ctrl
// Directed bench for adrv9001_tx_lane_ctrl. Instance u_dut is the wide
// configuration (4 lanes x 8 bits, lane 1 swapped, 16 training words);
// u_nar is a narrow configuration (2 lanes x 4 bits, lane 1 swapped,
// pattern 4'b0011, 3 training words). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_adrv9001_tx_lane_ctrl;

    localparam logic [31:0] IDLE_W  = 32'h0000FF00;  // lane1 inverted zero
    localparam logic [31:0] TRAIN_W = 32'hA5A55AA5;  // A5 everywhere, lane1 inverted

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] d;
    logic [3:0]  t;
    logic [1:0]  state;
    logic [15:0] ucnt;

    logic        enable_n;
    logic [7:0]  s_data_n;
    logic        s_valid_n;
    logic        s_ready_n;
    logic [7:0]  d_n;
    logic [1:0]  t_n;
    logic [1:0]  state_n;
    logic [15:0] ucnt_n;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    adrv9001_tx_lane_ctrl #(
        .LANES(4), .DATA_WIDTH(8), .SWAP_DIFF(4'b0010),
        .TRAIN_CYCLES(16), .TRAIN_PATTERN(8'hA5)
    ) u_dut (
        .serdes_clk_div (clk),
        .rst            (rst),
        .enable         (enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .d              (d),
        .t              (t),
        .state          (state),
        .underflow_cnt  (ucnt)
    );

    adrv9001_tx_lane_ctrl #(
        .LANES(2), .DATA_WIDTH(4), .SWAP_DIFF(2'b10),
        .TRAIN_CYCLES(3), .TRAIN_PATTERN(8'h03)
    ) u_nar (
        .serdes_clk_div (clk),
        .rst            (rst),
        .enable         (enable_n),
        .s_data         (s_data_n),
        .s_valid        (s_valid_n),
        .s_ready        (s_ready_n),
        .d              (d_n),
        .t              (t_n),
        .state          (state_n),
        .underflow_cnt  (ucnt_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  words;
        bit  bad;

        rst       = 1'b1;
        enable    = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        enable_n  = 1'b1;
        s_data_n  = '0;
        s_valid_n = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_state",   state,   2'd0);
        check("rst_t",       t,       4'hF);
        check("rst_ready",   s_ready, 1'b0);
        check("rst_ucnt",    ucnt,    16'd0);
        check("rst_d",       d,       IDLE_W);
        check("rst_d_nar",   d_n,     8'hF0);
        check("rst_t_nar",   t_n,     2'b11);

        // Release between edges; first edge after release must not train.
        #5 rst = 1'b0;
        tick();
        check("rel_edge1_state", state, 2'd0);
        check("rel_edge1_t",     t,     4'hF);

        // ---------------- bring-up ----------------
        tick();
        check("train_state", state, 2'd1);
        check("train_t",     t,     4'h0);
        check("train_d",     d,     TRAIN_W);
        check("train_ready", s_ready, 1'b0);
        check("nar_train_d", d_n,   8'h3C);
        check("nar_train_t", t_n,   2'b00);

        words = 1;
        bad   = 1'b0;
        for (int k = 0; k < 40 && state == 2'd1; k++) begin
            tick();
            if (state == 2'd1) begin
                words++;
                if (d !== TRAIN_W || t !== 4'h0) bad = 1'b1;
            end
        end
        check("train_words",   words,   16);
        check("train_stable",  bad,     1'b0);
        check("active_state",  state,   2'd2);
        check("active_ready",  s_ready, 1'b1);

        // ---------------- data path ----------------
        s_valid = 1'b1;
        s_data  = 32'hC30F0180;
        tick();
        check("data0_d", d, 32'hC3F07F01);
        s_data  = 32'h12345678;
        tick();
        check("data1_d", d, 32'h482C951E);
        check("data_ucnt", ucnt, 16'd0);

        // ---------------- underflow ----------------
        s_valid = 1'b0;
        bad     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (d !== IDLE_W) bad = 1'b1;
        end
        check("uf_idle_words", bad,  1'b0);
        check("uf_cnt5",       ucnt, 16'd5);

        for (int k = 0; k < 70000; k++) tick();
        check("uf_saturate", ucnt,  16'hFFFF);
        check("uf_state",    state, 2'd2);

        // ---------------- shutdown from ACTIVE ----------------
        enable  = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        tick();
        check("dr_state",  state,   2'd3);
        check("dr_ready",  s_ready, 1'b0);
        check("dr_d",      d,       IDLE_W);
        check("dr_t",      t,       4'h0);
        s_valid = 1'b0;
        tick();
        check("dr2_state", state,   2'd3);
        tick();
        check("off_state", state,   2'd0);
        check("off_t",     t,       4'hF);
        check("off_ucnt",  ucnt,    16'hFFFF);

        // ---------------- shutdown race ----------------
        enable = 1'b1;
        tick();
        check("re_train_state", state, 2'd1);
        check("re_train_ucnt",  ucnt,  16'd0);
        tick();
        tick();
        enable = 1'b0;  // after the third training word
        tick();
        check("race_dr1_state", state, 2'd3);
        check("race_dr1_d",     d,     IDLE_W);
        enable = 1'b1;  // re-raised during DRAIN
        tick();
        check("race_dr2_state", state, 2'd3);
        check("race_dr2_t",     t,     4'h0);
        tick();
        check("race_off_state", state, 2'd0);
        check("race_off_t",     t,     4'hF);
        tick();
        check("race_train_state", state, 2'd1);
        check("race_train_t",     t,     4'h0);
        check("race_train_ucnt",  ucnt,  16'd0);

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 40 && state != 2'd2; k++) tick();
        check("mid_active", state, 2'd2);
        s_valid = 1'b1;
        s_data  = 32'h12345678;
        tick();
        check("mid_d", d, 32'h482C951E);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", state,   2'd0);
        check("mid_rst_t",     t,       4'hF);
        check("mid_rst_ready", s_ready, 1'b0);
        check("mid_rst_d",     d,       IDLE_W);
        check("mid_rst_d_nar", d_n,     8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/adrv9001_tx_lane_ctrl.md
# adrv9001_tx_lane_ctrl

Fabric-side transmit lane controller for the ADRV9001 LVDS/CMOS SSI. It feeds the per-lane 8:1 or 4:1 output serialiser and its tristate input. It generalises lane count, serialisation width and per-lane pair swap, and adds a link state machine (tristate off, training pattern, active, drain) with a valid/ready handshake and underflow accounting. It sits between the TX sample formatter and the per-lane OSERDES/OBUFTDS instances.

## Interface
- `LANES`, 4: number of serial lanes (1–8).
- `DATA_WIDTH`, 8: serialisation ratio per lane; only 4 or 8 are legal, and elaboration fails on any other value.
- `SWAP_DIFF`, 0: `LANES`-bit mask. A set bit means that lane's P/N pins are physically swapped, so its data is inverted.
- `TRAIN_CYCLES`, 16: number of divided-clock cycles of training pattern (1–65535).
- `TRAIN_PATTERN`, 8'hA5: training word. Only the low `DATA_WIDTH` bits are used, and the same word goes on every lane.
- `serdes_clk_div`  in  1  divided serdes clock; this is the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level request to bring the link up (1) or down (0).
- `s_data`  in  `LANES*DATA_WIDTH`  parallel words; lane l occupies `[l*DATA_WIDTH +: DATA_WIDTH]`, MSB is transmitted first.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  the block accepts `s_data` this cycle.
- `d`  out  `LANES*DATA_WIDTH`  serialiser parallel input, per lane, bit 0 transmitted first.
- `t`  out  `LANES`  serialiser tristate input; 1 means the output is high-Z.
- `state`  out  2  current state: 0 OFF, 1 TRAIN, 2 ACTIVE, 3 DRAIN.
- `underflow_cnt`  out  16  count of ACTIVE cycles with no valid data; saturates at 16'hFFFF.

## Operation
- All outputs are registered.
- Per-lane formatting:
  - Bit-reverse the lane word: `d[l][i] = w[DATA_WIDTH-1-i]`.
  - Then XOR every bit with `SWAP_DIFF[l]`.
  - Formatting applies to every word in every state, including idle zeros.
- State machine:
  - OFF: `t` is all ones; the pre-format word is 0. Go to TRAIN when `enable`=1.
  - TRAIN: `t` is all zeros; the pre-format word is `TRAIN_PATTERN`. After exactly `TRAIN_CYCLES` words, go to ACTIVE. If `enable`=0 at any point, go to DRAIN immediately.
  - ACTIVE: `s_ready`=1.
    - `s_valid`=1: the pre-format word is `s_data`.
    - `s_valid`=0: the pre-format word is 0, and `underflow_cnt` increments by 1.
    - `enable`=0: go to DRAIN. The beat presented in that same cycle is not accepted, because `s_ready` is already low in DRAIN.
  - DRAIN: `t` stays all zeros; the pre-format word is 0 for exactly 2 cycles; then go to OFF.
    - DRAIN always completes, even if `enable` returns high.
    - A re-raised `enable` is then honoured from OFF on the next cycle.
- `s_ready` is 1 only while `state`=ACTIVE. A handshake is `s_valid & s_ready`.
- `underflow_cnt` clears to 0 on the cycle of entry to TRAIN, and holds its value in OFF and DRAIN.

## Timing
- Reset values:
  - `state`=OFF, `t`=all ones, `s_ready`=0, `underflow_cnt`=0.
  - Lane l of `d` = `{DATA_WIDTH{SWAP_DIFF[l]}}`, i.e. formatted zero.
- Reset mid-operation: outputs take their reset values asynchronously. Release is synchronous to `serdes_clk_div`; the first possible TRAIN is on the 2nd edge after release.
- `enable` sampled high in OFF at edge n:
  - `state`=TRAIN, `t`=0 and the first pattern word all appear after edge n.
  - The last pattern word appears after edge n+`TRAIN_CYCLES`−1.
  - ACTIVE starts after edge n+`TRAIN_CYCLES`.
- Data latency: a beat accepted at edge n appears on `d` after edge n (one register stage). Back-to-back beats produce gapless output.
- `enable` sampled low in ACTIVE or TRAIN at edge n:
  - DRAIN occupies the cycles after edges n and n+1.
  - `t`=all ones and OFF take effect after edge n+2.
- The training counter is 16 bits, loads at TRAIN entry, and never wraps.

## Structure
- Shared package `adrv9001_pkg`:
  - 2-bit state enum (OFF/TRAIN/ACTIVE/DRAIN).
  - Constant `DRAIN_CYCLES`=2.
  - Legal-width check function for `DATA_WIDTH`.
- One sub-module, `adrv9001_tx_lane_fmt`:
  - Combinational bit-reverse plus invert for one lane, parameterised by `DATA_WIDTH` and `SWAP`.
  - Generated `LANES` times, feeding the shared output register.
- FSM, counters and the handshake live in the top level.

## Test plan
- **Bring-up:** LANES=4, DW=8, TRAIN_CYCLES=16, raise `enable` → `t` goes 1111→0000 together with the first `d` lane word 8'hA5 (0xA5 is bit-reverse-symmetric); exactly 16 pattern words are sent, then `s_ready`=1.
- **Data path:** SWAP_DIFF=4'b0010, send `s_data` lane1=8'h01, lane0=8'h80 → `d` lane0=8'h01, lane1=8'h7F, one cycle after the handshake.
- **Underflow:** drop `s_valid` for 5 ACTIVE cycles → formatted-zero words are sent and `underflow_cnt`=5; force 70000 idle cycles → `underflow_cnt`=16'hFFFF.
- **Shutdown race:** drop `enable` on cycle 3 of TRAIN, then re-raise it in DRAIN → 2 drain words, `t`=all ones for exactly 1 cycle, a new TRAIN starts, and `underflow_cnt`=0.
- **Reset mid-stream:** assert `rst` between clock edges in ACTIVE → `t`, `s_ready`, `state` and `d` take their reset values before the next edge.
- **Narrow mode:** DW=4, TRAIN_PATTERN=4'b0011 → `d` lane word=4'b1100 while in TRAIN.
